// File: rtl/control_pipe.sv
// control_pipe: ID-stage control decode for a classic 5-stage MIPS-like pipe.
// Decoded EX/MEM/WB control bundles advance through ID/EX, EX/MEM and MEM/WB.
// A RUN/STALL FSM covers load-use hazards: each hazard holds the PC and the
// IF/ID register for STALL_CYC cycles in total, and a bubble enters ID/EX on
// every one of those cycles.
//
// Handshake: there is no backpressure into this block. When valid_i=1 the ID
// stage holds an instruction. stall_o=1 means "this instruction was not taken;
// present it again next cycle". flush_i=1 kills the ID instruction outright.
module control_pipe #(
  parameter int REGW      = 5,
  parameter int STALL_CYC = 1,
  parameter int EN_EXT    = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [5:0]      op_i,
  input  logic [REGW-1:0] rs_i,
  input  logic [REGW-1:0] rt_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            jump_o,
  output logic            branch_o,
  output logic            bne_o,
  output logic [3:0]      ex_o,
  output logic [1:0]      mem_o,
  output logic [1:0]      wb_o,
  output logic            illegal_o,
  output logic            state_o
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // Counter value at which the final STALL cycle ends.
  localparam logic [1:0] CNT_LAST = 2'(STALL_CYC - 1);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t          state;
  logic [1:0]      cnt;

  logic [3:0]      dec_ex;
  logic [1:0]      dec_mem;
  logic [1:0]      dec_wb;
  logic            dec_jump;
  logic            dec_branch;
  logic            dec_bne;
  logic            dec_known;
  logic            uses_rt;

  logic [3:0]      idex_ex;
  logic [1:0]      idex_mem;
  logic [1:0]      idex_wb;
  logic [REGW-1:0] idex_rt;
  logic [1:0]      exmem_mem;
  logic [1:0]      exmem_wb;
  logic [1:0]      memwb_wb;

  logic            hazard;
  logic            issue;

  // Opcode decode into control bundles; unknown opcodes decode to all zero.
  always_comb begin
    dec_ex     = 4'b0000;
    dec_mem    = 2'b00;
    dec_wb     = 2'b00;
    dec_jump   = 1'b0;
    dec_branch = 1'b0;
    dec_bne    = 1'b0;
    dec_known  = 1'b1;
    uses_rt    = 1'b0;
    case (op_i)
      OP_R: begin
        dec_ex  = 4'b0101;
        dec_wb  = 2'b10;
        uses_rt = 1'b1;
      end
      OP_ADDI: begin
        dec_ex = 4'b1000;
        dec_wb = 2'b10;
      end
      OP_LW: begin
        dec_ex  = 4'b1000;
        dec_mem = 2'b01;
        dec_wb  = 2'b11;
      end
      OP_SW: begin
        dec_ex  = 4'b1000;
        dec_mem = 2'b10;
        uses_rt = 1'b1;
      end
      OP_BEQ: begin
        dec_ex     = 4'b0010;
        dec_branch = 1'b1;
        uses_rt    = 1'b1;
      end
      OP_J: begin
        dec_jump = 1'b1;
      end
      OP_BNE: begin
        if (EN_EXT != 0) begin
          dec_ex  = 4'b0010;
          dec_bne = 1'b1;
          uses_rt = 1'b1;
        end else begin
          dec_known = 1'b0;
        end
      end
      OP_ORI: begin
        if (EN_EXT != 0) begin
          dec_ex = 4'b1110;
          dec_wb = 2'b10;
        end else begin
          dec_known = 1'b0;
        end
      end
      default: dec_known = 1'b0;
    endcase
  end

  // Load-use detection against the load sitting in ID/EX. In STALL the ID/EX
  // register only ever holds bubbles, so detection matters only in RUN.
  always_comb begin
    hazard = 1'b0;
    if (state == RUN && valid_i && idex_mem[0] && (idex_rt != '0)) begin
      hazard = (idex_rt == rs_i) || (uses_rt && (idex_rt == rt_i));
    end
  end

  // Stall / issue qualification and the gated ID-stage branch decode.
  always_comb begin
    stall_o  = !flush_i && ((state == STALL) || hazard);
    issue    = valid_i && !stall_o && !flush_i;
    jump_o   = issue && dec_jump;
    branch_o = issue && dec_branch;
    bne_o    = issue && dec_bne;
  end

  // Pipeline registers; anything not issued enters ID/EX as an all-zero bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_ex   <= '0;
      idex_mem  <= '0;
      idex_wb   <= '0;
      idex_rt   <= '0;
      exmem_mem <= '0;
      exmem_wb  <= '0;
      memwb_wb  <= '0;
      illegal_o <= 1'b0;
    end else begin
      idex_ex   <= issue ? dec_ex  : 4'b0000;
      idex_mem  <= issue ? dec_mem : 2'b00;
      idex_wb   <= issue ? dec_wb  : 2'b00;
      idex_rt   <= issue ? rt_i    : '0;
      exmem_mem <= idex_mem;
      exmem_wb  <= idex_wb;
      memwb_wb  <= exmem_wb;
      illegal_o <= issue && !dec_known;
    end
  end

  // RUN/STALL FSM. The detecting cycle is the first stall cycle, so STALL is
  // entered only when more than one stall cycle is wanted; cnt saturates at
  // CNT_LAST and never wraps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else if (flush_i) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (hazard && (STALL_CYC > 1)) begin
            state <= STALL;
            cnt   <= 2'd1;
          end
        end
        STALL: begin
          if (cnt >= CNT_LAST) begin
            state <= RUN;
            cnt   <= 2'd0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

  assign ex_o    = idex_ex;
  assign mem_o   = exmem_mem;
  assign wb_o    = memwb_wb;
  assign state_o = state;

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 SHALL have parameter REGW, default 5, meaning register-address width.
REQ-002 SHALL have parameter STALL_CYC, default 1, legal range 1..3, meaning bubble cycles per load-use hazard.
REQ-003 SHALL have parameter EN_EXT, default 1, meaning that decode of bne (000101) and ori (001101) is enabled.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all flops SHALL be clocked on its rising edge.
REQ-005 SHALL have port rst_i, input, 1; reset SHALL be asynchronous and active-high.
REQ-006 SHALL have port valid_i, input, 1, meaning the ID stage holds a valid instruction.
REQ-007 SHALL have port op_i, input, 6, the ID-stage opcode.
REQ-008 SHALL have ports rs_i and rt_i, inputs, REGW each, the ID-stage source registers.
REQ-009 SHALL have port flush_i, input, 1, meaning kill the ID instruction (taken branch or jump).
REQ-010 SHALL have port stall_o, output, 1, meaning hold the PC and the IF/ID register.
REQ-011 SHALL have ports jump_o, branch_o and bne_o, outputs, 1 each, the ID-stage combinational decode.
REQ-012 SHALL have port ex_o, output, 4, {ALUSrc, ALUOp[1:0], RegDst}, driven from the ID/EX register.
REQ-013 SHALL have port mem_o, output, 2, {MemWrite, MemRead}, driven from the EX/MEM register.
REQ-014 SHALL have port wb_o, output, 2, {RegWrite, MemtoReg}, driven from the MEM/WB register.
REQ-015 SHALL have port illegal_o, output, 1, a registered one-cycle pulse for an unknown opcode.

Function
REQ-016 Decode (EX/MEM/WB) SHALL be: R 000000 -> 0101/00/10; addi 001000 -> 1000/00/10; lw 100011 -> 1000/01/11; sw 101011 -> 1000/10/00; beq 000100 -> 0010/00/00 with branch_o=1; j 000010 -> all-zero bundles with jump_o=1.
REQ-017 When EN_EXT=1, decode SHALL add bne -> 0010/00/00 with bne_o=1, and ori -> 1110/00/10; when EN_EXT=0 these two opcodes SHALL be treated as unknown.
REQ-018 An unknown opcode with valid_i=1 SHALL produce all-zero bundles and SHALL pulse illegal_o in the next cycle.
REQ-019 Bundles SHALL advance ID->ID/EX->EX/MEM->MEM/WB every cycle, so ex_o, mem_o and wb_o reflect an ID decode at latency 1, 2 and 3 cycles respectively.
REQ-020 A bubble SHALL be an all-zero bundle; valid_i=0 SHALL insert a bubble.
REQ-021 ID/EX SHALL also hold rt and a MemRead flag for hazard detection.
REQ-022 A load-use hazard SHALL be flagged when all of the following hold: valid_i=1; ID/EX MemRead=1; ID/EX rt is nonzero; and ID/EX rt equals rs_i, or equals rt_i for R, sw, beq or bne.
REQ-023 The FSM SHALL have two states, RUN and STALL: RUN goes to STALL on a hazard with flush_i=0; STALL returns to RUN after STALL_CYC cycles.
REQ-024 In STALL, and in the detecting cycle, stall_o SHALL be 1, a bubble SHALL enter ID/EX, and EX/MEM and MEM/WB SHALL keep advancing.
REQ-025 The held instruction SHALL issue into ID/EX in the first RUN cycle after STALL.
REQ-026 flush_i=1 SHALL override everything: bubble into ID/EX, jump_o=branch_o=bne_o=0, stall_o=0, FSM to RUN and stall counter cleared, including when a hazard or a STALL occurs in the same cycle.
REQ-027 jump_o, branch_o and bne_o SHALL be 0 whenever stall_o=1 or valid_i=0.
REQ-028 The stall counter SHALL be 2 bits wide and SHALL NOT wrap past STALL_CYC.

Reset
REQ-029 rst_i=1 SHALL immediately clear all pipeline registers, the counter and illegal_o, and force state RUN.
REQ-030 While rst_i=1, ex_o, mem_o, wb_o, stall_o and illegal_o SHALL be 0.
REQ-031 Reset asserted mid-stall SHALL abort the stall; the first edge after release SHALL decode op_i normally.

Verification
REQ-032 lw, R, sw, addi, beq and j issued back-to-back with no dependencies -> each bundle appears per REQ-016 at +1/+2/+3 cycles and stall_o stays 0.
REQ-033 lw with rt=5, then R with rs=5 (STALL_CYC=1) -> stall_o=1 for one cycle, ex_o=0000 for one cycle, then ex_o=0101.
REQ-034 Same dependency with STALL_CYC=3 -> stall_o high for 3 cycles and 3 bubbles; lw with rt=0 -> no stall.
REQ-035 Hazard cycle with flush_i=1 -> stall_o=0 and bubble inserted; flush_i=1 during a STALL -> FSM returns to RUN the next cycle.
REQ-036 op_i=111111 with valid_i=1 -> bundles all zero and illegal_o pulses for 1 cycle; op_i=000101 with EN_EXT=0 -> illegal_o=1 and bne_o=0.
REQ-037 rst_i asserted between clock edges during a STALL -> all outputs 0 asynchronously; after release, a normal decode follows.
